bypass_regfile: RTL
===================

BYPASS_REGFILE -- requirements
Module: bypass_regfile

Interface
REQ-001 SHALL have parameter NUM_READ, default 4, meaning number of read ports.
REQ-002 SHALL have parameter NUM_WRITE, default 4, meaning number of write ports (one per writeback channel).
REQ-003 SHALL have parameter DEPTH, default 64, meaning number of physical registers (power of two, >=2).
REQ-004 SHALL have parameter DATA_WIDTH, default 32, meaning register width; AW = $clog2(DEPTH).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-007 SHALL have port ren  input  NUM_READ  per-port read enable.
REQ-008 SHALL have port raddr  input  NUM_READ x AW  per-port read address.
REQ-009 SHALL have port rdata  output  NUM_READ x DATA_WIDTH  per-port read data.
REQ-010 SHALL have port rvalid  output  NUM_READ  per-port read-data valid.
REQ-011 SHALL have port we  input  NUM_WRITE  per-port write enable.
REQ-012 SHALL have port waddr  input  NUM_WRITE x AW  per-port write address.
REQ-013 SHALL have port wdata  input  NUM_WRITE x DATA_WIDTH  per-port write data.
REQ-014 SHALL have port ready  output  1  high once init sweep complete; array usable.
REQ-015 SHALL have port wconflict  output  1  registered pulse: two or more effective writes hit one address in the previous cycle.

Function
REQ-016 SHALL implement a two-state FSM: INIT and RUN.
REQ-017 In INIT, an AW-bit counter SHALL clear entry[counter] to 0 each cycle and increment; when counter == DEPTH-1 that cycle, FSM SHALL move to RUN next cycle (INIT lasts exactly DEPTH cycles).
REQ-018 ready SHALL be 0 in INIT and 1 in RUN.
REQ-019 In INIT, we and ren SHALL be ignored: no array writes, rvalid stays 0, rdata holds 0.
REQ-020 In RUN, a write port is effective when we[i]=1 and waddr[i]!=0; entry 0 SHALL never be written and SHALL always read 0.
REQ-021 Effective writes SHALL update the array at the rising edge ending the cycle they are presented.
REQ-022 If several effective writes target the same address in one cycle, the highest-index port SHALL win; wconflict SHALL be 1 for the following cycle only.
REQ-023 Reads SHALL have 1-cycle latency: ren[j]=1 in cycle N -> rdata[j], rvalid[j]=1 in cycle N+1.
REQ-024 ren[j]=0 in cycle N -> rvalid[j]=0 in N+1 and rdata[j] SHALL hold its previous value.
REQ-025 Write-first bypass: if in cycle N a read and an effective write share an address, rdata in N+1 SHALL equal that write's data (highest-index winner per REQ-022).
REQ-026 raddr=0 SHALL return 0 regardless of any write to address 0.
REQ-027 Any number of read ports MAY read one address in the same cycle; all SHALL return the same value.
REQ-028 Timing: bypass compare and priority mux SHALL be combinational in the read-address cycle; no combinational path from any input to any output.

Reset
REQ-029 While rst=0 at a rising edge: FSM -> INIT, counter -> 0, ready -> 0, rvalid -> 0, rdata -> 0, wconflict -> 0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart the full DEPTH-cycle sweep; in-flight reads SHALL be dropped (rvalid 0).
REQ-031 Array contents SHALL NOT be reset directly; they are defined only by the init sweep.

Verification
REQ-032 Reset release, DEPTH=64 -> ready=0 for exactly 64 cycles, then 1; every address reads 0 after ready.
REQ-033 RUN: write 0xDEADBEEF to addr 5 on port 0 in cycle N, read addr 5 on port 2 in cycle N -> rdata[2]=0xDEADBEEF, rvalid[2]=1 in N+1.
REQ-034 Ports 0 and 3 write 0x11 and 0x33 to addr 7 same cycle -> wconflict=1 next cycle only; later read of addr 7 returns 0x33.
REQ-035 Write 0xFFFFFFFF to addr 0, read addr 0 same and next cycle -> rdata=0 both times, wconflict stays 0.
REQ-036 Read addr 9 (value 0xA5) cycle N, ren=0 cycle N+1 -> rdata holds 0xA5 with rvalid=0 in N+2.
REQ-037 Assert rst for 1 cycle at cycle 20 of RUN with reads pending -> rvalid=0 next cycle, ready=0, writes ignored for 64 cycles, all entries read 0 afterward.

Source files
------------

// File: rtl/bypass_regfile.sv
// bypass_regfile: multi-port register file with a power-up clear sweep,
// write-first read bypass, and a registered same-address write conflict flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | clearing entry[cnt] each cycle; ports ignored, ready low
// RUN   | array usable; reads 1-cycle latency with write-first bypass
module bypass_regfile #(
  parameter int NUM_READ   = 4,
  parameter int NUM_WRITE  = 4,
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_READ-1:0]                  ren,
  input  logic [NUM_READ-1:0][AW-1:0]          raddr,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata,
  output logic [NUM_READ-1:0]                  rvalid,
  input  logic [NUM_WRITE-1:0]                 we,
  input  logic [NUM_WRITE-1:0][AW-1:0]         waddr,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wdata,
  output logic                                 ready,
  output logic                                 wconflict
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                              state;
  logic [AW-1:0]                       cnt;
  logic [DATA_WIDTH-1:0]               mem [DEPTH];
  logic [NUM_WRITE-1:0]                weff;
  logic                                conflict;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0] rbyp;

  // A write only counts in RUN and never to entry 0, which is hardwired to zero.
  always_comb begin
    weff = '0;
    for (int i = 0; i < NUM_WRITE; i++)
      weff[i] = (state == RUN) && we[i] && (waddr[i] != '0);
  end

  // Flag any pair of effective writes landing on the same entry.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WRITE; i++)
      for (int k = i + 1; k < NUM_WRITE; k++)
        if (weff[i] && weff[k] && (waddr[i] == waddr[k]))
          conflict = 1'b1;
  end

  // Read mux with write-first bypass; later ports override earlier ones so the
  // highest-index writer wins, matching the array update order below.
  always_comb begin
    rbyp = '0;
    for (int j = 0; j < NUM_READ; j++) begin
      rbyp[j] = mem[raddr[j]];
      for (int i = 0; i < NUM_WRITE; i++)
        if (weff[i] && (waddr[i] == raddr[j]))
          rbyp[j] = wdata[i];
      if (raddr[j] == '0)
        rbyp[j] = '0;
    end
  end

  // Sequencer: DEPTH-cycle clear sweep after every reset, then RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Array storage: no direct reset, contents are established by the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else begin
        for (int i = 0; i < NUM_WRITE; i++)
          if (weff[i])
            mem[waddr[i]] <= wdata[i];
      end
    end
  end

  // Registered read outputs and conflict pulse; rdata holds when not read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid    <= '0;
      rdata     <= '0;
      wconflict <= 1'b0;
    end else begin
      wconflict <= conflict;
      for (int j = 0; j < NUM_READ; j++) begin
        rvalid[j] <= ren[j] && (state == RUN);
        if (ren[j] && (state == RUN))
          rdata[j] <= rbyp[j];
      end
    end
  end

endmodule
